// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: data width and FSM state encoding.
package timer_pkg;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clr wins over en so that a tick coinciding with a clear is dropped
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_unit.sv
// Prescaled down-counting timer with load, pause, snapshot read and a
// one-cycle terminal-count interrupt pulse.
module timer_unit
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH       = TIMER_W,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned AUTO_RELOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_cs,
  input  logic             timer_wr,
  input  logic             timer_start,
  input  logic             timer_rd,
  input  logic [WIDTH-1:0] timer_datain,
  output logic [WIDTH-1:0] timer_value,
  output logic             timer_INT
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             int_q, int_d;
  logic             wr_d1_q, wr_d1_d;
  logic             run_d1_q, run_d1_d;

  logic wr_qual, run_qual, rd_qual;
  logic wr_rise, run_rise;
  logic presc_clr, presc_en, tick;

  assign wr_qual  = timer_cs & timer_wr;
  assign run_qual = timer_cs & timer_start;
  assign rd_qual  = timer_cs & timer_rd;
  assign wr_rise  = wr_qual & ~wr_d1_q;
  assign run_rise = run_qual & ~run_d1_q;

  // Holding the prescaler clear outside RUN makes every entry to RUN start a fresh period
  assign presc_clr = wr_rise | (state_q != ST_RUN);
  assign presc_en  = (state_q == ST_RUN) & run_qual;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_d   = load_q;
    value_d  = rd_qual ? count_q : value_q;
    int_d    = 1'b0;
    wr_d1_d  = wr_qual;
    run_d1_d = run_qual;

    if (wr_rise) begin
      load_d  = timer_datain;
      count_d = timer_datain;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_rise) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (run_qual) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run_qual) begin
          state_d = ST_ARMED;
        end else if (tick) begin
          if (count_q == '0) begin
            int_d = 1'b1;
            if (AUTO_RELOAD != 0) count_d = load_q;
            else                  state_d = ST_EXPIRED;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      ST_EXPIRED: begin
        if (wr_rise) begin
          state_d = ST_ARMED;
        end else if (run_rise) begin
          count_d = load_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      load_q   <= '0;
      value_q  <= '0;
      int_q    <= 1'b0;
      wr_d1_q  <= 1'b0;
      run_d1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      load_q   <= load_d;
      value_q  <= value_d;
      int_q    <= int_d;
      wr_d1_q  <= wr_d1_d;
      run_d1_q <= run_d1_d;
    end
  end

  assign timer_value = value_q;
  assign timer_INT   = int_q;

endmodule
